// File: rtl/winograd_filter_xform_pipe.sv
// Two-stage elastic Winograd F(2x2,3x3) filter transform U = G.g.G^T with channel tagging.
// Define WINO_XFORM_ROUND_EN to round half toward +inf on the /2 and /4 scaling instead of flooring.
module winograd_filter_xform_pipe #(
    parameter int W      = 8,
    parameter int OUT_W  = W + 2,
    parameter int NUM_CH = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [9*W-1:0]      in_filter,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*OUT_W-1:0] out_filter,
    output logic [CH_W-1:0]     out_ch,
    output logic                out_last
);
    localparam int TW = W + 2;
    localparam int SW = W + 4;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic                 r_s1_valid;
    logic signed [TW-1:0] r_t [4][3];
    logic                 r_s2_valid;
    logic [16*OUT_W-1:0]  r_u;
    logic [CH_W-1:0]      r_ch;
    logic                 r_last;

    logic                 w_s1_load;
    logic                 w_s2_load;
    logic signed [TW-1:0] w_t [4][3];
    logic signed [SW-1:0] w_s [4][4];
    logic [16*OUT_W-1:0]  w_u;

    function automatic logic signed [TW-1:0] sx_in(input logic [W-1:0] v);
        return {{(TW - W){v[W-1]}}, v};
    endfunction

    function automatic logic signed [SW-1:0] sx_t(input logic [TW-1:0] v);
        return {{(SW - TW){v[TW-1]}}, v};
    endfunction

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load && !rst;

    // Column pass with the unscaled G' = [1 0 0; 1 1 1; 1 -1 1; 0 0 1].
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            w_t[0][c] = sx_in(in_filter[c*W +: W]);
            w_t[1][c] = sx_in(in_filter[c*W +: W]) + sx_in(in_filter[(3+c)*W +: W])
                      + sx_in(in_filter[(6+c)*W +: W]);
            w_t[2][c] = sx_in(in_filter[c*W +: W]) - sx_in(in_filter[(3+c)*W +: W])
                      + sx_in(in_filter[(6+c)*W +: W]);
            w_t[3][c] = sx_in(in_filter[(6+c)*W +: W]);
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w_s[r][0] = sx_t(r_t[r][0]);
            w_s[r][1] = sx_t(r_t[r][0]) + sx_t(r_t[r][1]) + sx_t(r_t[r][2]);
            w_s[r][2] = sx_t(r_t[r][0]) - sx_t(r_t[r][1]) + sx_t(r_t[r][2]);
            w_s[r][3] = sx_t(r_t[r][2]);
        end
    end

    // The halves in G become a per-position shift: one per middle row/column index.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int K = ((r == 1 || r == 2) ? 1 : 0) + ((c == 1 || c == 2) ? 1 : 0);
            logic signed [SW-1:0] w_sh;
            if (K == 0) begin : g_k0
                assign w_sh = w_s[r][c];
            end else begin : g_kn
`ifdef WINO_XFORM_ROUND_EN
                localparam logic signed [SW-1:0] RND = SW'(1 << (K - 1));
                assign w_sh = (w_s[r][c] + RND) >>> K;
`else
                assign w_sh = w_s[r][c] >>> K;
`endif
            end
            if (OUT_W >= SW) begin : g_wide
                assign w_u[(r*4+c)*OUT_W +: OUT_W] = OUT_W'(w_sh);
            end else begin : g_sat
                localparam logic signed [SW-1:0] MAXV = SW'((1 << (OUT_W - 1)) - 1);
                localparam logic signed [SW-1:0] MINV = SW'(-(1 << (OUT_W - 1)));
                assign w_u[(r*4+c)*OUT_W +: OUT_W] = (w_sh > MAXV) ? OUT_W'(MAXV) :
                                                     (w_sh < MINV) ? OUT_W'(MINV) :
                                                                     OUT_W'(w_sh);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_s1_load && in_valid) begin
            r_t <= w_t;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_u        <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_u <= w_u;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch   <= '0;
            r_last <= (NUM_CH == 1);
        end else if (r_s2_valid && out_ready) begin
            if (r_ch == LAST_CH) begin
                r_ch   <= '0;
                r_last <= (NUM_CH == 1);
            end else begin
                r_ch   <= r_ch + 1'b1;
                r_last <= ((r_ch + 1'b1) == LAST_CH);
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_filter = r_u;
    assign out_ch     = r_ch;
    assign out_last   = r_last;

endmodule
